// File: rtl/d_cache_if.sv
// CPU and memory side signals of the data cache, grouped into one bundle.
// master: the environment (CPU pipeline plus memory model); slave: the cache.
// The bidirectional memory data bus stays a plain inout port on the cache.
interface d_cache_if #(
  parameter int unsigned WORD_SIZE = 16
);
  logic                 c_readM;
  logic                 c_writeM;
  logic [WORD_SIZE-1:0] c_address;
  logic [WORD_SIZE-1:0] c_wdata;
  logic [WORD_SIZE-1:0] c_rdata;
  logic                 c_ready;
  logic                 m_readM;
  logic                 m_writeM;
  logic [WORD_SIZE-1:0] m_address;
  logic                 m_ready;
  logic [15:0]          hit_count;
  logic [15:0]          miss_count;

  modport master (
    output c_readM, c_writeM, c_address, c_wdata, m_ready,
    input  c_rdata, c_ready, m_readM, m_writeM, m_address, hit_count, miss_count
  );

  modport slave (
    input  c_readM, c_writeM, c_address, c_wdata, m_ready,
    output c_rdata, c_ready, m_readM, m_writeM, m_address, hit_count, miss_count
  );
endinterface

// File: rtl/d_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache.
// Load hits complete combinationally; load misses fill a whole line one word
// per memory handshake; stores always go to memory and update a resident line.
module d_cache #(
  parameter int unsigned WORD_SIZE  = 16,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned NUM_LINES  = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  d_cache_if.slave             bus,
  inout  wire  [WORD_SIZE-1:0] m_data
);

  localparam int unsigned OFF_W = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W = $clog2(NUM_LINES);
  localparam int unsigned TAG_W = WORD_SIZE - OFF_W - IDX_W;
  localparam logic [OFF_W-1:0] LastWord = OFF_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {StIdle, StFill, StWrite} state_e;

  state_e               state_q;
  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [WORD_SIZE-1:0] data_q [NUM_LINES][LINE_WORDS];
  logic [OFF_W-1:0]     cnt_q;
  logic [WORD_SIZE-1:0] wdata_q;
  logic                 m_readM_q;
  logic                 m_writeM_q;
  logic [WORD_SIZE-1:0] m_address_q;
  logic [15:0]          hit_q;
  logic [15:0]          miss_q;
  // Set for the one cycle in which a just-filled load replays as a hit, so the
  // completion of a miss is not also counted as a hit.
  logic                 replay_q;

  // CPU address split
  logic [OFF_W-1:0] c_off;
  logic [IDX_W-1:0] c_idx;
  logic [TAG_W-1:0] c_tag;
  // Latched memory address split; during a fill its offset equals cnt_q
  logic [OFF_W-1:0] m_off;
  logic [IDX_W-1:0] m_idx;
  logic [TAG_W-1:0] m_tag;

  logic hit;
  logic load_hit;
  logic fill_we;
  logic write_hit_we;

  assign c_off = bus.c_address[OFF_W-1:0];
  assign c_idx = bus.c_address[OFF_W +: IDX_W];
  assign c_tag = bus.c_address[WORD_SIZE-1 -: TAG_W];
  assign m_off = m_address_q[OFF_W-1:0];
  assign m_idx = m_address_q[OFF_W +: IDX_W];
  assign m_tag = m_address_q[WORD_SIZE-1 -: TAG_W];

  // Lookup, handshake and data-array write enables
  always_comb begin
    hit          = valid_q[c_idx] && (tag_q[c_idx] == c_tag);
    load_hit     = (state_q == StIdle) && bus.c_readM && !bus.c_writeM && hit;
    fill_we      = (state_q == StFill) && bus.m_ready;
    write_hit_we = (state_q == StWrite) && bus.m_ready && valid_q[m_idx] &&
                   (tag_q[m_idx] == m_tag);
  end

  assign bus.c_ready    = load_hit || ((state_q == StWrite) && bus.m_ready);
  assign bus.c_rdata    = data_q[c_idx][c_off];
  assign bus.m_readM    = m_readM_q;
  assign bus.m_writeM   = m_writeM_q;
  assign bus.m_address  = m_address_q;
  assign bus.hit_count  = hit_q;
  assign bus.miss_count = miss_q;

  // The memory data bus is driven only while a write is outstanding
  assign m_data = m_writeM_q ? wdata_q : {WORD_SIZE{1'bz}};

  // Line data array: fill words from memory, or patch a resident word on store
  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_q[m_idx][m_off] <= m_data;
    end else if (write_hit_we) begin
      data_q[m_idx][m_off] <= wdata_q;
    end
  end

  // Control FSM with registered memory-side outputs and counters
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      valid_q    <= '0;
      cnt_q      <= '0;
      m_readM_q  <= 1'b0;
      m_writeM_q <= 1'b0;
      hit_q      <= 16'd0;
      miss_q     <= 16'd0;
      replay_q   <= 1'b0;
    end else begin
      replay_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.c_writeM) begin
            // Stores win over a simultaneous load and are never allocated
            m_address_q <= bus.c_address;
            wdata_q     <= bus.c_wdata;
            m_writeM_q  <= 1'b1;
            state_q     <= StWrite;
          end else if (bus.c_readM) begin
            if (hit) begin
              if (!replay_q) begin
                hit_q <= hit_q + 16'd1;
              end
            end else begin
              miss_q         <= miss_q + 16'd1;
              // Drop the victim now so a partial fill can never hit
              valid_q[c_idx] <= 1'b0;
              m_address_q    <= {bus.c_address[WORD_SIZE-1:OFF_W], {OFF_W{1'b0}}};
              cnt_q          <= '0;
              m_readM_q      <= 1'b1;
              state_q        <= StFill;
            end
          end
        end
        StFill: begin
          if (bus.m_ready) begin
            if (cnt_q == LastWord) begin
              valid_q[m_idx] <= 1'b1;
              tag_q[m_idx]   <= m_tag;
              cnt_q          <= '0;
              m_readM_q      <= 1'b0;
              replay_q       <= 1'b1;
              state_q        <= StIdle;
            end else begin
              cnt_q       <= cnt_q + OFF_W'(1);
              m_address_q <= m_address_q + WORD_SIZE'(1);
            end
          end
        end
        StWrite: begin
          if (bus.m_ready) begin
            m_writeM_q <= 1'b0;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
